// File: rtl/clock_pkg.sv
// Shared types and helpers for the time-of-day / alarm blocks.
package clock_pkg;

  // BCD hour {tens[1:0], units[3:0]} and BCD minute {tens[2:0], units[3:0]}
  typedef logic [5:0] bcd_hour_t;
  typedef logic [6:0] bcd_min_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RING      = 2'd1,
    SNOOZE_ST = 2'd2
  } alm_state_t;

  // True when hour is 00..23 and minute is 00..59 with every nibble a BCD digit
  function automatic logic bcd_time_valid(input bcd_hour_t h, input bcd_min_t m);
    logic hour_ok;
    logic min_ok;
    hour_ok = (h[3:0] <= 4'd9) &&
              ((h[5:4] < 2'd2) || ((h[5:4] == 2'd2) && (h[3:0] <= 4'd3)));
    min_ok  = (m[3:0] <= 4'd9) && (m[6:4] <= 3'd5);
    return hour_ok && min_ok;
  endfunction

endpackage

// File: rtl/alarm_ctrl_multi_if.sv
// Bus bundle between the alarm controller and its host (time counters,
// buttons, display and annunciators).
interface alarm_ctrl_multi_if
  import clock_pkg::*;
#(
  parameter int N_ALARM = 4
);
  localparam int SW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  // time base
  logic          en1hz;
  logic          sig2hz;
  bcd_hour_t     hour;
  bcd_min_t      minute;
  // slot programming
  logic          al_we;
  logic [SW-1:0] al_sel;
  bcd_hour_t     al_hour;
  bcd_min_t      al_min;
  logic          al_en;
  // user buttons
  logic          stop;
  logic          snooze;
  // readback for the display
  logic [SW-1:0] rd_sel;
  bcd_hour_t     rd_hour;
  bcd_min_t      rd_min;
  logic          rd_en;
  // annunciators and status
  logic          ring;
  logic          buzz;
  logic          led;
  logic [SW-1:0] ring_id;
  logic          wr_err;

  modport master (
    output en1hz, sig2hz, hour, minute,
    output al_we, al_sel, al_hour, al_min, al_en,
    output stop, snooze, rd_sel,
    input  rd_hour, rd_min, rd_en,
    input  ring, buzz, led, ring_id, wr_err
  );

  modport slave (
    input  en1hz, sig2hz, hour, minute,
    input  al_we, al_sel, al_hour, al_min, al_en,
    input  stop, snooze, rd_sel,
    output rd_hour, rd_min, rd_en,
    output ring, buzz, led, ring_id, wr_err
  );

endinterface

// File: rtl/alarm_slot_file.sv
// Alarm slot storage: validated writes, display readback, per-slot match
// against the current time of day.
module alarm_slot_file
  import clock_pkg::*;
#(
  parameter int N_ALARM = 4,
  parameter int SW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [SW-1:0]      sel,
  input  bcd_hour_t          wr_hour,
  input  bcd_min_t           wr_min,
  input  logic               wr_en,
  input  logic [SW-1:0]      rd_sel,
  input  bcd_hour_t          cur_hour,
  input  bcd_min_t           cur_min,
  output bcd_hour_t          rd_hour,
  output bcd_min_t           rd_min,
  output logic               rd_en,
  output logic [N_ALARM-1:0] match,
  output logic               accept,
  output logic               wr_err
);

  bcd_hour_t slot_hour [N_ALARM];
  bcd_min_t  slot_min  [N_ALARM];
  logic      slot_en   [N_ALARM];

  // A write lands only if the time is legal BCD and the slot exists
  assign accept = we && bcd_time_valid(wr_hour, wr_min) && (32'(sel) < N_ALARM);

  // Slot registers
  // NOTE: the slot array is reset explicitly because "all alarms cleared and
  // disabled" is visible behaviour after reset, so it cannot map to plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        slot_hour[i] <= '0;
        slot_min[i]  <= '0;
        slot_en[i]   <= 1'b0;
      end
    end else if (accept) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      slot_hour[sel] <= wr_hour;
      slot_min[sel]  <= wr_min;
      slot_en[sel]   <= wr_en;
    end
  end

  // Rejected write flag, one cycle after the offending strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= we && !accept;
  end

  // Display readback; out-of-range selects read as a cleared slot
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    rd_hour = '0;
    rd_min  = '0;
    rd_en   = 1'b0;
    if (32'(rd_sel) < N_ALARM) begin
      rd_hour = slot_hour[rd_sel];
      rd_min  = slot_min[rd_sel];
      rd_en   = slot_en[rd_sel];
    end
  end

  // Per-slot compare against the live time of day
  always_comb begin
    for (int i = 0; i < N_ALARM; i++) begin
      match[i] = slot_en[i] && (slot_hour[i] == cur_hour) && (slot_min[i] == cur_min);
    end
  end

endmodule

// File: rtl/alarm_ctrl_multi.sv
// Multi-alarm controller: minute-edge trigger with lowest-slot priority,
// ring / snooze / auto-silence state machine, buzzer and LED drive.
module alarm_ctrl_multi
  import clock_pkg::*;
#(
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input logic               clk,
  input logic               rst_n,
  alarm_ctrl_multi_if.slave bus
);

  localparam int SW         = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
  localparam int SNZ_TICKS  = SNOOZE_MIN * 60;
  localparam int RW         = $clog2(RING_SEC + 1);
  localparam int NW         = $clog2(SNZ_TICKS + 1);
  localparam int CW         = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [1:0]    ST_IDLE   = 2'(IDLE);
  localparam logic [1:0]    ST_RING   = 2'(RING);
  localparam logic [1:0]    ST_SNOOZE = 2'(SNOOZE_ST);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [NW-1:0] SNZ_LOAD  = NW'(SNZ_TICKS);
  localparam logic [NW-1:0] SNZ_ONE   = NW'(1);
  localparam logic [CW-1:0] SNZ_MAX   = CW'(MAX_SNOOZE);

  logic [N_ALARM-1:0] match;
  logic               accept;
  logic               wr_err;
  bcd_hour_t          rd_hour;
  bcd_min_t           rd_min;
  logic               rd_en;

  alarm_slot_file #(
    .N_ALARM (N_ALARM),
    .SW      (SW)
  ) u_slots (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.al_we),
    .sel      (bus.al_sel),
    .wr_hour  (bus.al_hour),
    .wr_min   (bus.al_min),
    .wr_en    (bus.al_en),
    .rd_sel   (bus.rd_sel),
    .cur_hour (bus.hour),
    .cur_min  (bus.minute),
    .rd_hour  (rd_hour),
    .rd_min   (rd_min),
    .rd_en    (rd_en),
    .match    (match),
    .accept   (accept),
    .wr_err   (wr_err)
  );

  logic [12:0]   prev_time;
  logic          minute_edge;
  logic          hit;
  logic [SW-1:0] winner;
  logic          trigger;
  logic          cancel;

  logic [1:0]    state,    state_nx;
  logic [RW-1:0] ring_cnt, ring_cnt_nx;
  logic [NW-1:0] snz_cnt,  snz_cnt_nx;
  logic [CW-1:0] snz_num,  snz_num_nx;
  logic [SW-1:0] ring_id,  ring_id_nx;
  logic          ring_q, buzz_q, led_q;

  // Registered copy of the time of day, refreshed every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_time <= '0;
    else        prev_time <= {bus.hour, bus.minute};
  end

  assign minute_edge = ({bus.hour, bus.minute} != prev_time);

  // Priority encoder: lowest matching slot wins
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit    = 1'b1;
        winner = SW'(i);
      end
    end
  end

  assign trigger = minute_edge && hit;
  // Reprogramming the slot that owns the live event kills the event
  assign cancel  = accept && (bus.al_sel == ring_id) && (state != ST_IDLE);

  // Next-state and counter update; any transition swallows a coincident tick
  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    snz_num_nx  = snz_num;
    ring_id_nx  = ring_id;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nx    = ST_RING;
          ring_id_nx  = winner;
          ring_cnt_nx = '0;
          snz_num_nx  = '0;
        end
      end
      ST_RING: begin
        if (cancel || bus.stop) begin
          state_nx = ST_IDLE;
        end else if (bus.snooze) begin
          if (snz_num < SNZ_MAX) begin
            state_nx   = ST_SNOOZE;
            snz_num_nx = snz_num + 1'b1;
            snz_cnt_nx = SNZ_LOAD;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (bus.en1hz) begin
          ring_cnt_nx = ring_cnt + 1'b1;
          if (ring_cnt == RING_LAST) state_nx = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (cancel || bus.stop) begin
          state_nx = ST_IDLE;
        end else if (trigger) begin
          state_nx    = ST_RING;
          ring_id_nx  = winner;
          ring_cnt_nx = '0;
          snz_num_nx  = '0;
        end else if (bus.en1hz) begin
          snz_cnt_nx = snz_cnt - 1'b1;
          if (snz_cnt == SNZ_ONE) begin
            state_nx    = ST_RING;
            ring_cnt_nx = '0;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters and registered annunciators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_num  <= '0;
      ring_id  <= '0;
      ring_q   <= 1'b0;
      buzz_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
      snz_cnt  <= snz_cnt_nx;
      snz_num  <= snz_num_nx;
      ring_id  <= ring_id_nx;
      ring_q   <= (state_nx == ST_RING);
      buzz_q   <= (state_nx == ST_RING) && bus.sig2hz;
      led_q    <= (state_nx == ST_RING) || ((state_nx == ST_SNOOZE) && bus.sig2hz);
    end
  end

  assign bus.ring    = ring_q;
  assign bus.buzz    = buzz_q;
  assign bus.led     = led_q;
  assign bus.ring_id = ring_id;
  assign bus.wr_err  = wr_err;
  assign bus.rd_hour = rd_hour;
  assign bus.rd_min  = rd_min;
  assign bus.rd_en   = rd_en;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Bench for alarm_ctrl_multi: directed scenarios followed by random traffic,
// every cycle compared with an event-level model of the alarm behaviour.
module tb_alarm_ctrl_multi;

  localparam int N    = 4;
  localparam int RSEC = 60;
  localparam int SNZ  = 5 * 60;
  localparam int MAXS = 3;

  typedef enum int {M_QUIET, M_RINGING, M_SNOOZED} mode_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_ctrl_multi_if #(.N_ALARM(N)) bus ();

  alarm_ctrl_multi #(
    .N_ALARM    (N),
    .RING_SEC   (RSEC),
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (MAXS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [5:0]  m_sh [N];
  logic [6:0]  m_sm [N];
  logic        m_en [N];
  logic [12:0] m_prev;
  mode_t       m_mode;
  int          m_elapsed, m_remaining, m_snoozes, m_id;
  logic        e_ring, e_buzz, e_led, e_wr_err;

  logic [12:0] tl [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_time(input logic [5:0] h, input logic [6:0] m);
    int ht, hu, mt, mu;
    ht = int'(h[5:4]); hu = int'(h[3:0]);
    mt = int'(m[6:4]); mu = int'(m[3:0]);
    return (hu <= 9) && (mu <= 9) && (ht * 10 + hu <= 23) && (mt * 10 + mu <= 59);
  endfunction

  function automatic logic [12:0] bcd_time(input int h, input int m);
    logic [5:0] bh;
    logic [6:0] bm;
    bh = 6'((h / 10) * 16 + h % 10);
    bm = 7'((m / 10) * 16 + m % 10);
    return {bh, bm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i] = '0; m_sm[i] = '0; m_en[i] = 1'b0;
    end
    m_prev = '0; m_mode = M_QUIET;
    m_elapsed = 0; m_remaining = 0; m_snoozes = 0; m_id = 0;
    e_ring = 0; e_buzz = 0; e_led = 0; e_wr_err = 0;
  endtask

  // One clock edge of the alarm rules, using the inputs present at that edge
  task automatic model_step();
    bit acc, edge_seen, trig, cancel;
    int win;
    acc       = bus.al_we && legal_time(bus.al_hour, bus.al_min);
    edge_seen = ({bus.hour, bus.minute} != m_prev);
    win = -1;
    for (int i = 0; i < N; i++)
      if (win < 0 && m_en[i] && m_sh[i] == bus.hour && m_sm[i] == bus.minute) win = i;
    trig   = edge_seen && (win >= 0);
    cancel = acc && (int'(bus.al_sel) == m_id) && (m_mode != M_QUIET);
    case (m_mode)
      M_QUIET:
        if (trig) begin
          m_mode = M_RINGING; m_id = win; m_elapsed = 0; m_snoozes = 0;
        end
      M_RINGING:
        if (cancel || bus.stop) m_mode = M_QUIET;
        else if (bus.snooze) begin
          if (m_snoozes < MAXS) begin
            m_mode = M_SNOOZED; m_snoozes++; m_remaining = SNZ;
          end else m_mode = M_QUIET;
        end else if (bus.en1hz) begin
          m_elapsed++;
          if (m_elapsed == RSEC) m_mode = M_QUIET;
        end
      default:
        if (cancel || bus.stop) m_mode = M_QUIET;
        else if (trig) begin
          m_mode = M_RINGING; m_id = win; m_elapsed = 0; m_snoozes = 0;
        end else if (bus.en1hz) begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_mode = M_RINGING; m_elapsed = 0;
          end
        end
    endcase
    if (acc) begin
      m_sh[bus.al_sel] = bus.al_hour;
      m_sm[bus.al_sel] = bus.al_min;
      m_en[bus.al_sel] = bus.al_en;
    end
    m_prev   = {bus.hour, bus.minute};
    e_wr_err = bus.al_we && !acc;
    e_ring   = (m_mode == M_RINGING);
    e_buzz   = e_ring && bus.sig2hz;
    e_led    = e_ring || ((m_mode == M_SNOOZED) && bus.sig2hz);
  endtask

  task automatic check_all();
    check("ring",    32'(bus.ring),    32'(e_ring));
    check("buzz",    32'(bus.buzz),    32'(e_buzz));
    check("led",     32'(bus.led),     32'(e_led));
    check("wr_err",  32'(bus.wr_err),  32'(e_wr_err));
    check("ring_id", 32'(bus.ring_id), 32'(m_id));
    check("rd_hour", 32'(bus.rd_hour), 32'(m_sh[bus.rd_sel]));
    check("rd_min",  32'(bus.rd_min),  32'(m_sm[bus.rd_sel]));
    check("rd_en",   32'(bus.rd_en),   32'(m_en[bus.rd_sel]));
  endtask

  // One cycle: edge, model, compare after settling, then drop 1-cycle pulses
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.en1hz = 0; bus.stop = 0; bus.snooze = 0; bus.al_we = 0;
  endtask

  task automatic write_slot(input int sel, input logic [5:0] h, input logic [6:0] m, input logic en);
    bus.al_we = 1; bus.al_sel = 2'(sel); bus.al_hour = h; bus.al_min = m; bus.al_en = en;
    cyc();
  endtask

  task automatic set_time(input logic [5:0] h, input logic [6:0] m);
    bus.hour = h; bus.minute = m;
    cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.en1hz = 1;
      cyc();
    end
  endtask

  task automatic press_snooze();
    bus.snooze = 1;
    cyc();
  endtask

  initial begin
    bus.en1hz = 0; bus.sig2hz = 0; bus.hour = '0; bus.minute = '0;
    bus.al_we = 0; bus.al_sel = '0; bus.al_hour = '0; bus.al_min = '0; bus.al_en = 0;
    bus.stop = 0; bus.snooze = 0; bus.rd_sel = '0;
    tl[0] = {6'h07, 7'h30}; tl[1] = {6'h12, 7'h00}; tl[2] = {6'h12, 7'h05};
    tl[3] = {6'h23, 7'h59}; tl[4] = {6'h00, 7'h00}; tl[5] = {6'h07, 7'h29};
    model_reset();

    // reset state
    #12;
    check("rst_ring", 32'(bus.ring), 32'd0);
    check("rst_led",  32'(bus.led),  32'd0);
    check("rst_id",   32'(bus.ring_id), 32'd0);
    check("rst_rden", 32'(bus.rd_en), 32'd0);
    rst_n = 1;
    cyc();

    // 1: single alarm fires one cycle after the minute edge; buzz follows 2 Hz
    write_slot(0, 6'h07, 7'h30, 1'b1);
    set_time(6'h07, 7'h29);
    check("t1_pre_ring", 32'(bus.ring), 32'd0);
    set_time(6'h07, 7'h30);
    check("t1_ring", 32'(bus.ring), 32'd1);
    check("t1_id",   32'(bus.ring_id), 32'd0);
    bus.sig2hz = 1; cyc();
    check("t1_buzz_hi", 32'(bus.buzz), 32'd1);
    bus.sig2hz = 0; cyc();
    check("t1_buzz_lo", 32'(bus.buzz), 32'd0);
    check("t1_led",     32'(bus.led),  32'd1);

    // 2: auto-silence on the 60th tick
    ticks(RSEC - 1);
    check("t2_still", 32'(bus.ring), 32'd1);
    ticks(1);
    check("t2_silent", 32'(bus.ring), 32'd0);

    // 3: three snoozes, each returns after 300 ticks; the fourth ends the event
    set_time(6'h07, 7'h29);
    set_time(6'h07, 7'h30);
    check("t3_ring", 32'(bus.ring), 32'd1);
    bus.sig2hz = 1;
    for (int k = 0; k < MAXS; k++) begin
      press_snooze();
      check("t3_snz_ring", 32'(bus.ring), 32'd0);
      check("t3_snz_led",  32'(bus.led),  32'd1);
      bus.sig2hz = 0; cyc();
      check("t3_blink", 32'(bus.led), 32'd0);
      bus.sig2hz = 1;
      ticks(SNZ - 1);
      check("t3_wait", 32'(bus.ring), 32'd0);
      ticks(1);
      check("t3_back", 32'(bus.ring), 32'd1);
    end
    press_snooze();
    check("t3_4th_ring", 32'(bus.ring), 32'd0);
    check("t3_4th_led",  32'(bus.led),  32'd0);

    // 4: lowest slot wins; a new match pre-empts a snooze and resets its count
    write_slot(1, 6'h12, 7'h00, 1'b1);
    write_slot(3, 6'h12, 7'h00, 1'b1);
    write_slot(2, 6'h12, 7'h05, 1'b1);
    set_time(6'h11, 7'h59);
    set_time(6'h12, 7'h00);
    check("t4_id1", 32'(bus.ring_id), 32'd1);
    press_snooze();
    set_time(6'h12, 7'h05);
    check("t4_preempt", 32'(bus.ring), 32'd1);
    check("t4_id2",     32'(bus.ring_id), 32'd2);
    for (int k = 0; k < MAXS; k++) begin
      press_snooze();
      check("t4_snz_ok", 32'(bus.ring), 32'd0);
      ticks(SNZ);
      check("t4_rering", 32'(bus.ring), 32'd1);
    end
    press_snooze();
    check("t4_4th", 32'(bus.led), 32'd0);

    // 5: illegal writes rejected; reprogramming the ringing slot cancels
    bus.rd_sel = 2'd0;
    write_slot(0, 6'h24, 7'h00, 1'b1);
    check("t5_err_24", 32'(bus.wr_err), 32'd1);
    write_slot(0, 6'h10, 7'h60, 1'b1);
    check("t5_err_60", 32'(bus.wr_err), 32'd1);
    write_slot(0, 6'h1A, 7'h00, 1'b1);
    check("t5_err_1a", 32'(bus.wr_err), 32'd1);
    check("t5_keep_h", 32'(bus.rd_hour), 32'h07);
    check("t5_keep_m", 32'(bus.rd_min),  32'h30);
    cyc();
    check("t5_err_gone", 32'(bus.wr_err), 32'd0);
    set_time(6'h07, 7'h29);
    set_time(6'h07, 7'h30);
    check("t5_ring", 32'(bus.ring), 32'd1);
    write_slot(0, 6'h07, 7'h30, 1'b0);
    check("t5_cancel", 32'(bus.ring), 32'd0);
    check("t5_rd_en",  32'(bus.rd_en), 32'd0);

    // 6: STOP beats SNOOZE; asynchronous reset mid-ring
    set_time(6'h11, 7'h59);
    set_time(6'h12, 7'h00);
    check("t6_ring", 32'(bus.ring), 32'd1);
    bus.stop = 1; bus.snooze = 1; cyc();
    check("t6_stop_wins", 32'(bus.ring), 32'd0);
    check("t6_led",       32'(bus.led),  32'd0);
    set_time(6'h11, 7'h59);
    bus.sig2hz = 1;
    set_time(6'h12, 7'h00);
    check("t6_buzz", 32'(bus.buzz), 32'd1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t6_rst_ring", 32'(bus.ring), 32'd0);
    check("t6_rst_buzz", 32'(bus.buzz), 32'd0);
    check("t6_rst_led",  32'(bus.led),  32'd0);
    for (int s = 0; s < N; s++) begin
      bus.rd_sel = 2'(s);
      #1 check("t6_rst_rden", 32'(bus.rd_en), 32'd0);
    end
    @(negedge clk);
    rst_n = 1;
    cyc();

    // random traffic against the model
    for (int s = 0; s < N; s++) write_slot(s, tl[s][12:7], tl[s][6:0], 1'b1);
    for (int c = 0; c < 8000; c++) begin
      int pick;
      bus.en1hz  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) bus.sig2hz = ~bus.sig2hz;
      bus.stop   = ($urandom_range(0, 299) == 0);
      bus.snooze = ($urandom_range(0, 49) == 0);
      bus.rd_sel = 2'($urandom_range(0, N - 1));
      if ($urandom_range(0, 29) == 0) begin
        logic [12:0] t;
        pick = $urandom_range(0, 7);
        t = (pick < 6) ? tl[pick] : bcd_time($urandom_range(0, 23), $urandom_range(0, 59));
        bus.hour = t[12:7]; bus.minute = t[6:0];
      end
      if ($urandom_range(0, 149) == 0) begin
        logic [12:0] t;
        bus.al_we  = 1;
        bus.al_sel = 2'($urandom_range(0, N - 1));
        bus.al_en  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) t = tl[$urandom_range(0, 5)];
        else t = 13'($urandom());
        bus.al_hour = t[12:7]; bus.al_min = t[6:0];
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
